// File: rtl/pps_mon_pkg.sv
// Shared definitions for the PPS phase monitor.
//   state_t      : qualification state (idle / acquiring / locked)
//   SyncLatency  : cycles from a pin edge to its detection in clk_tf; the
//                  measurements are not compensated for it, so consumers
//                  subtract it themselves.
package pps_mon_pkg;

    typedef enum logic [1:0] {
        S_idle = 2'd0,
        S_acq  = 2'd1,
        S_lock = 2'd2
    } state_t;

    localparam int SyncLatency = 3;

endpackage

// File: rtl/pps_edge_sync.sv
// Three-flop synchronizer for the asynchronous raw PPS pin plus rising-edge
// detect.
// Ports:
//   clk_tf        in  timing clock
//   tf_reset      in  synchronous active-high reset
//   pps_raw_logic in  raw PPS pin (asynchronous)
//   raw_rise      out 1-cycle strobe, SyncLatency cycles after the pin rises
module pps_edge_sync
    import pps_mon_pkg::*;
(
    input  logic clk_tf,
    input  logic tf_reset,
    input  logic pps_raw_logic,
    output logic raw_rise
);

    // sync_chain[0] = d1, [1] = d2, [2] = d3
    logic [SyncLatency-1:0] sync_chain;

    always_ff @(posedge clk_tf) begin
        if (tf_reset) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SyncLatency-2:0], pps_raw_logic};
        end
    end

    // d2 & ~d3: a held-high pin produces exactly one strobe.
    assign raw_rise = sync_chain[1] & ~sync_chain[2];

endmodule

// File: rtl/pps_phase_monitor.sv
// Qualifies the raw GPS PPS and measures it against the local top-of-second.
// Per detected raw edge it reports the period since the previous edge and the
// phase relative to the last top-of-second, plus lock / missing status.
// Ports:
//   clk_tf        in  timing clock
//   tf_reset      in  synchronous active-high reset
//   pps_raw_logic in  raw PPS pin (asynchronous)
//   tos_mark      in  1-cycle pulse; next clk_tf edge is top of second
//   meas_valid    out 1-cycle strobe qualifying meas_* and period_ok
//   meas_phase    out cycles from top of second to raw-edge detection
//   meas_period   out cycles between successive detections (0 if none before)
//   period_ok     out meas_period within ClocksPerSecond +/- PeriodTolerance
//   pps_locked    out level, raw PPS qualified
//   pps_missing   out 1-cycle pulse, expected raw edge did not arrive
module pps_phase_monitor
    import pps_mon_pkg::*;
#(
    parameter int ClocksPerSecond = 19200000,
    parameter int PeriodTolerance = 192,
    parameter int GoodCountLock   = 4,
    parameter int CountWidth      = $clog2(ClocksPerSecond + PeriodTolerance + 2)
) (
    input  logic                  clk_tf,
    input  logic                  tf_reset,
    input  logic                  pps_raw_logic,
    input  logic                  tos_mark,
    output logic                  meas_valid,
    output logic [CountWidth-1:0] meas_phase,
    output logic [CountWidth-1:0] meas_period,
    output logic                  period_ok,
    output logic                  pps_locked,
    output logic                  pps_missing
);

    localparam int GoodW = $clog2(GoodCountLock + 1);

    localparam logic [CountWidth-1:0] WinLo = CountWidth'(ClocksPerSecond - PeriodTolerance);
    localparam logic [CountWidth-1:0] WinHi = CountWidth'(ClocksPerSecond + PeriodTolerance);
    localparam logic [GoodW-1:0]      GoodTarget = GoodW'(GoodCountLock);

    logic                  raw_rise;
    logic [CountWidth-1:0] phase_count;
    logic [CountWidth-1:0] period_count;
    logic [CountWidth:0]   period_ext;
    logic                  in_win;
    logic                  timeout;

    state_t                state, state_next;
    logic [GoodW-1:0]      good_count, good_next;

    logic [CountWidth-1:0] period_out_next;
    logic                  period_ok_next;

    pps_edge_sync u_sync (
        .clk_tf        (clk_tf),
        .tf_reset      (tf_reset),
        .pps_raw_logic (pps_raw_logic),
        .raw_rise      (raw_rise)
    );

    // Free-running counters, both saturating at all-ones.
    always_ff @(posedge clk_tf) begin
        if (tf_reset) begin
            phase_count  <= '0;
            period_count <= '0;
        end else begin
            if (tos_mark) begin
                phase_count <= '0;
            end else if (phase_count != '1) begin
                phase_count <= phase_count + 1'b1;
            end

            if (raw_rise) begin
                period_count <= '0;
            end else if (period_count != '1) begin
                period_count <= period_count + 1'b1;
            end
        end
    end

    // One extra bit so P = period_count + 1 cannot wrap when the counter is
    // saturated (only possible while idle, where P is not reported).
    assign period_ext = {1'b0, period_count} + 1'b1;
    assign in_win     = (period_ext >= {1'b0, WinLo}) && (period_ext <= {1'b0, WinHi});

    // A rise in the timeout cycle wins; it is handled as an out-of-window edge.
    assign timeout = (state != S_idle) && (period_count == WinHi) && !raw_rise;

    // State register
    always_ff @(posedge clk_tf) begin
        if (tf_reset) begin
            state      <= S_idle;
            good_count <= '0;
        end else begin
            state      <= state_next;
            good_count <= good_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        good_next  = good_count;
        case (state)
            S_idle: begin
                if (raw_rise) begin
                    state_next = S_acq;
                    good_next  = '0;
                end
            end
            S_acq: begin
                if (raw_rise) begin
                    if (in_win) begin
                        good_next = good_count + 1'b1;
                        if (good_count + 1'b1 == GoodTarget) begin
                            state_next = S_lock;
                        end
                    end else begin
                        good_next = '0;
                    end
                end else if (timeout) begin
                    state_next = S_idle;
                    good_next  = '0;
                end
            end
            S_lock: begin
                if (raw_rise) begin
                    if (!in_win) begin
                        state_next = S_acq;
                        good_next  = '0;
                    end
                end else if (timeout) begin
                    state_next = S_idle;
                    good_next  = '0;
                end
            end
            default: begin
                state_next = S_idle;
                good_next  = '0;
            end
        endcase
    end

    // Output logic: no previous edge exists while idle, so the period is 0.
    always_comb begin
        period_out_next = '0;
        period_ok_next  = 1'b0;
        if (state != S_idle) begin
            period_out_next = period_ext[CountWidth-1:0];
            period_ok_next  = in_win;
        end
    end

    always_ff @(posedge clk_tf) begin
        if (tf_reset) begin
            meas_valid  <= 1'b0;
            meas_phase  <= '0;
            meas_period <= '0;
            period_ok   <= 1'b0;
            pps_locked  <= 1'b0;
            pps_missing <= 1'b0;
        end else begin
            meas_valid  <= raw_rise;
            pps_locked  <= (state == S_lock);
            pps_missing <= timeout;
            if (raw_rise) begin
                // Pre-update phase: a coincident tos_mark is not yet applied.
                meas_phase  <= phase_count;
                meas_period <= period_out_next;
                period_ok   <= period_ok_next;
            end
        end
    end

endmodule

// File: tb/tb_pps_phase_monitor.sv
// Directed testbench for pps_phase_monitor with a 1000-cycle second.
module tb_pps_phase_monitor;

    localparam int CPS = 1000;
    localparam int TOL = 10;
    localparam int GCL = 4;
    localparam int CW  = $clog2(CPS + TOL + 2);

    logic          clk_tf = 1'b0;
    logic          tf_reset = 1'b1;
    logic          pps_raw_logic = 1'b0;
    logic          tos_mark = 1'b0;
    logic          meas_valid;
    logic [CW-1:0] meas_phase;
    logic [CW-1:0] meas_period;
    logic          period_ok;
    logic          pps_locked;
    logic          pps_missing;

    int errors = 0;
    int checks = 0;
    int since_raise = 0;

    logic          cap_valid;
    logic [CW-1:0] cap_period;
    logic          cap_ok;
    logic          cap_missing;
    logic          cap_locked;

    pps_phase_monitor #(
        .ClocksPerSecond (CPS),
        .PeriodTolerance (TOL),
        .GoodCountLock   (GCL)
    ) dut (
        .clk_tf        (clk_tf),
        .tf_reset      (tf_reset),
        .pps_raw_logic (pps_raw_logic),
        .tos_mark      (tos_mark),
        .meas_valid    (meas_valid),
        .meas_phase    (meas_phase),
        .meas_period   (meas_period),
        .period_ok     (period_ok),
        .pps_locked    (pps_locked),
        .pps_missing   (pps_missing)
    );

    always #5 clk_tf = ~clk_tf;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_tf);
        #1;
        since_raise++;
    endtask

    task automatic do_reset();
        tf_reset = 1'b1;
        pps_raw_logic = 1'b0;
        tos_mark = 1'b0;
        tick();
        tf_reset = 1'b0;
        tick();
    endtask

    // Raise the pin n cycles after the previous raise; returns at the cycle
    // where meas_valid for that edge is visible, with outputs captured.
    task automatic send_edge(input int n);
        while (since_raise < n) tick();
        pps_raw_logic = 1'b1;
        since_raise = 0;
        repeat (3) tick();
        cap_valid   = meas_valid;
        cap_period  = meas_period;
        cap_ok      = period_ok;
        cap_missing = pps_missing;
        cap_locked  = pps_locked;
        pps_raw_logic = 1'b0;
    endtask

    task automatic do_lock();
        do_reset();
        send_edge(20);
        repeat (GCL) send_edge(CPS);
        tick();
        checks++;
        if (pps_locked !== 1'b1) begin
            errors++;
            $display("FAIL do_lock_locked: got %0b expected 1", pps_locked);
        end
    endtask

    task automatic test_reset();
        tf_reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({meas_valid, period_ok, pps_locked, pps_missing} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {meas_valid, period_ok, pps_locked, pps_missing});
        end
        checks++;
        if (meas_phase !== '0 || meas_period !== '0) begin
            errors++;
            $display("FAIL reset_meas: got phase=%0d period=%0d expected 0/0", meas_phase, meas_period);
        end
        tf_reset = 1'b0;
        tick();
    endtask

    task automatic test_lock_acquire();
        do_reset();
        send_edge(20);
        checks++;
        if (cap_valid !== 1'b1 || cap_period !== '0 || cap_ok !== 1'b0) begin
            errors++;
            $display("FAIL first_edge: got valid=%0b period=%0d ok=%0b expected 1/0/0",
                     cap_valid, cap_period, cap_ok);
        end
        tick();
        checks++;
        if (meas_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_pulse_width: got %0b expected 0", meas_valid);
        end
        for (int i = 2; i <= 5; i++) begin
            send_edge(CPS);
            checks++;
            if (cap_valid !== 1'b1 || cap_period !== CW'(CPS) || cap_ok !== 1'b1) begin
                errors++;
                $display("FAIL edge%0d_period: got valid=%0b period=%0d ok=%0b expected 1/1000/1",
                         i, cap_valid, cap_period, cap_ok);
            end
            checks++;
            if (cap_locked !== 1'b0) begin
                errors++;
                $display("FAIL edge%0d_early_lock: got %0b expected 0", i, cap_locked);
            end
        end
        tick();
        checks++;
        if (pps_locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_after_5th: got %0b expected 1", pps_locked);
        end
    endtask

    task automatic test_phase();
        do_reset();
        tos_mark = 1'b1;
        tick();
        tos_mark = 1'b0;
        repeat (35) tick();
        pps_raw_logic = 1'b1;
        since_raise = 0;
        repeat (3) tick();
        pps_raw_logic = 1'b0;
        checks++;
        if (meas_valid !== 1'b1 || meas_phase !== CW'(37)) begin
            errors++;
            $display("FAIL phase_37: got valid=%0b phase=%0d expected 1/37", meas_valid, meas_phase);
        end
        // tos_mark coincides with the detection cycle
        tos_mark = 1'b1;
        tick();
        tos_mark = 1'b0;
        repeat (997) tick();
        pps_raw_logic = 1'b1;
        since_raise = 0;
        tick();
        tick();
        tos_mark = 1'b1;
        tick();
        tos_mark = 1'b0;
        pps_raw_logic = 1'b0;
        checks++;
        if (meas_valid !== 1'b1 || meas_phase !== CW'(999)) begin
            errors++;
            $display("FAIL phase_coincident: got valid=%0b phase=%0d expected 1/999", meas_valid, meas_phase);
        end
    endtask

    task automatic test_window();
        do_lock();
        send_edge(CPS + TOL + 1);
        checks++;
        if (cap_period !== CW'(1011) || cap_ok !== 1'b0 || cap_missing !== 1'b0) begin
            errors++;
            $display("FAIL period_1011: got period=%0d ok=%0b missing=%0b expected 1011/0/0",
                     cap_period, cap_ok, cap_missing);
        end
        tick();
        checks++;
        if (pps_locked !== 1'b0) begin
            errors++;
            $display("FAIL unlock_after_1011: got %0b expected 0", pps_locked);
        end
        send_edge(CPS + TOL);
        checks++;
        if (cap_period !== CW'(1010) || cap_ok !== 1'b1) begin
            errors++;
            $display("FAIL period_1010: got period=%0d ok=%0b expected 1010/1", cap_period, cap_ok);
        end
        send_edge(CPS - TOL);
        checks++;
        if (cap_period !== CW'(990) || cap_ok !== 1'b1) begin
            errors++;
            $display("FAIL period_990: got period=%0d ok=%0b expected 990/1", cap_period, cap_ok);
        end
        send_edge(CPS);
        send_edge(CPS);
        checks++;
        if (cap_locked !== 1'b0) begin
            errors++;
            $display("FAIL relock_early: got %0b expected 0", cap_locked);
        end
        tick();
        checks++;
        if (pps_locked !== 1'b1) begin
            errors++;
            $display("FAIL relock_after_4_good: got %0b expected 1", pps_locked);
        end
    endtask

    task automatic test_missing();
        do_lock();
        while (!pps_missing && since_raise < 3000) tick();
        checks++;
        if (pps_missing !== 1'b1 || since_raise != 1014) begin
            errors++;
            $display("FAIL missing_timing: got missing=%0b at %0d expected 1 at 1014",
                     pps_missing, since_raise);
        end
        tick();
        checks++;
        if (pps_missing !== 1'b0 || pps_locked !== 1'b0) begin
            errors++;
            $display("FAIL after_missing: got missing=%0b locked=%0b expected 0/0",
                     pps_missing, pps_locked);
        end
        send_edge(1500);
        checks++;
        if (cap_valid !== 1'b1 || cap_period !== '0 || cap_ok !== 1'b0) begin
            errors++;
            $display("FAIL edge_after_missing: got valid=%0b period=%0d ok=%0b expected 1/0/0",
                     cap_valid, cap_period, cap_ok);
        end
    endtask

    task automatic test_reset_mid_lock();
        do_lock();
        repeat (10) tick();
        tf_reset = 1'b1;
        tick();
        checks++;
        if ({meas_valid, period_ok, pps_locked, pps_missing} !== 4'b0000 ||
            meas_phase !== '0 || meas_period !== '0) begin
            errors++;
            $display("FAIL reset_mid_lock: got flags=%b phase=%0d period=%0d expected 0000/0/0",
                     {meas_valid, period_ok, pps_locked, pps_missing}, meas_phase, meas_period);
        end
        tf_reset = 1'b0;
        tick();
        send_edge(20);
        for (int i = 2; i <= 5; i++) begin
            tick();
            checks++;
            if (pps_locked !== 1'b0) begin
                errors++;
                $display("FAIL relock_edge%0d_early: got %0b expected 0", i - 1, pps_locked);
            end
            send_edge(CPS);
        end
        tick();
        checks++;
        if (pps_locked !== 1'b1) begin
            errors++;
            $display("FAIL relock_after_reset: got %0b expected 1", pps_locked);
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_phase();
        test_window();
        test_missing();
        test_reset_mid_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
